// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the hex-to-segment lookup.
package seg7_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a}; index 15 first.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_OFF   = 7'h00;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high segment pattern, with forced blanking.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_c
);

  assign seg_c = blank ? SEG_BLANK : hex7(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner stepped by the divider's toggle output;
// the display word is shadowed once per frame so a frame never tears.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned IDX_W          = $clog2(DIGITS),
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  tick_tgl,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lead,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [IDX_W-1:0]      digit_idx,
  output logic                  frame_done
);

  localparam logic [DIGITS-1:0] AN_DARK  = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_DARK  = SEG_ACTIVE_LOW;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic                  tick_d;
  logic [4*DIGITS-1:0]   sh_value;
  logic [DIGITS-1:0]     sh_dp;
  logic                  sh_blank;

  logic                  step, wrap;
  logic [IDX_W-1:0]      nxt_idx;
  logic [4*DIGITS-1:0]   nxt_value;
  logic [DIGITS-1:0]     nxt_dp;
  logic                  nxt_blank;
  logic [DIGITS-1:0]     sel, zero_run;
  logic                  run;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [6:0]            dec_seg_c;

  // Next digit and the data it will show; on a wrap the fresh inputs are used.
  always_comb begin
    step      = tick_tgl ^ tick_d;
    wrap      = step && enable && (digit_idx == IDX_LAST);
    nxt_idx   = wrap ? '0 : digit_idx + IDX_W'(1);
    nxt_value = wrap ? value : sh_value;
    nxt_dp    = wrap ? dp : sh_dp;
    nxt_blank = wrap ? blank_lead : sh_blank;
    sel       = '0;
    zero_run  = '0;
    run       = 1'b1;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    // zero_run[i]: every nibble from the top down to i is zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run         = run && (nxt_value[4*i +: 4] == 4'h0);
      zero_run[i] = run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      sel[i] = (nxt_idx == IDX_W'(i));
      if (sel[i]) begin
        cur_nib   = nxt_value[4*i +: 4];
        cur_dp    = nxt_dp[i];
        cur_blank = nxt_blank && zero_run[i] && (i != 0);
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .seg_c  (dec_seg_c)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tick_d     <= 1'b0;
      digit_idx  <= IDX_LAST;
      an         <= AN_DARK;
      seg        <= SEG_DARK;
      dp_out     <= DP_DARK;
      frame_done <= 1'b0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= 1'b0;
    end else begin
      tick_d     <= tick_tgl;
      frame_done <= wrap;
      if (!enable) begin
        an     <= AN_DARK;
        seg    <= SEG_DARK;
        dp_out <= DP_DARK;
      end else if (step) begin
        digit_idx <= nxt_idx;
        an        <= AN_ACTIVE_LOW ? ~sel : sel;
        seg       <= SEG_ACTIVE_LOW ? ~dec_seg_c : dec_seg_c;
        dp_out    <= cur_dp ^ SEG_ACTIVE_LOW;
        if (wrap) begin
          sh_value <= value;
          sh_dp    <= dp;
          sh_blank <= blank_lead;
        end
      end
    end
  end

endmodule
